// File: rtl/score_tracker.sv
// Rhythm-game score keeper: counts hit/miss rising edges during a fixed-length
// game, awards a double-point bonus on long streaks and flags a perfect score.
module score_tracker #(
    parameter int GAME_TICKS = 100_000_000,
    parameter int COMBO_LEN  = 4,
    parameter int TIMER_W    = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [4:0] score,
    output logic [2:0] streak,
    output logic       playing,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(GAME_TICKS - 1);
    localparam logic [4:0]         MAX_SCORE = 5'd31;
    localparam logic [2:0]         MAX_STREAK = 3'd7;

    state_t             state;
    state_t             state_nx;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nx;
    logic [4:0]         score_nx;
    logic [2:0]         streak_nx;
    logic [5:0]         sum;

    logic start_prev;
    logic hit_prev;
    logic miss_prev;
    logic start_edge;

    // Hit/miss edges are registered once so scoring lands one cycle after
    // the edge is sampled; start acts on the edge directly.
    logic hit_pend;
    logic miss_pend;

    assign start_edge = start & ~start_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            score      <= '0;
            streak     <= '0;
            timer      <= '0;
            start_prev <= 1'b0;
            hit_prev   <= 1'b0;
            miss_prev  <= 1'b0;
            hit_pend   <= 1'b0;
            miss_pend  <= 1'b0;
        end else begin
            state      <= state_nx;
            score      <= score_nx;
            streak     <= streak_nx;
            timer      <= timer_nx;
            start_prev <= start;
            hit_prev   <= hit;
            miss_prev  <= miss;
            hit_pend   <= hit & ~hit_prev;
            miss_pend  <= miss & ~miss_prev;
        end
    end

    always_comb begin
        state_nx  = state;
        score_nx  = score;
        streak_nx = streak;
        timer_nx  = timer;
        sum       = '0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_nx  = PLAY;
                    score_nx  = '0;
                    streak_nx = '0;
                    timer_nx  = '0;
                end
            end
            PLAY: begin
                // A simultaneous hit and miss counts as a miss only.
                if (miss_pend) begin
                    score_nx  = (score == 5'd0) ? 5'd0 : score - 5'd1;
                    streak_nx = '0;
                end else if (hit_pend) begin
                    sum       = {1'b0, score} + ((int'(streak) >= COMBO_LEN) ? 6'd2 : 6'd1);
                    score_nx  = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[4:0];
                    streak_nx = (streak == MAX_STREAK) ? MAX_STREAK : streak + 3'd1;
                end
                if (score_nx == MAX_SCORE) begin
                    state_nx = DONE;
                end
                // The final tick still scores; the game ends on the same edge.
                if (timer == LAST_TICK) begin
                    state_nx = DONE;
                end else begin
                    timer_nx = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == DONE);
    assign win       = (state == DONE) && (score == MAX_SCORE);

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: hand-derived vector table, corner-case sequences and
// randomized games checked every cycle against a rule-level reference model.
module tb_score_tracker;

    localparam int GT = 50;
    localparam int CL = 4;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hit;
    logic       miss;
    logic [4:0] score;
    logic [2:0] streak;
    logic       playing;
    logic       game_over;
    logic       win;

    always #5 clk = ~clk;

    score_tracker #(.GAME_TICKS(GT), .COMBO_LEN(CL), .TIMER_W(27)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .score(score), .streak(streak), .playing(playing),
        .game_over(game_over), .win(win)
    );

    typedef struct {
        logic       rst, start, hit, miss;
        logic [4:0] score;
        logic [2:0] streak;
        logic       playing, over, win;
    } vec_t;

    vec_t        vq[$];
    logic [10:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model: game rules in plain integer terms.
    int   m_state, m_score, m_streak, m_timer;
    logic m_prev_start, m_prev_hit, m_prev_miss;
    logic m_pend_hit, m_pend_miss;

    function automatic logic [10:0] pack_exp(int sc, int st, int stt);
        logic [4:0] s5;
        logic [2:0] t3;
        s5 = sc[4:0];
        t3 = st[2:0];
        return {s5, t3, stt == M_PLAY, stt == M_DONE, (stt == M_DONE) && (sc == 31)};
    endfunction

    task automatic model_step(input logic r, input logic s, input logic h, input logic m);
        if (r) begin
            m_state = M_IDLE; m_score = 0; m_streak = 0; m_timer = 0;
            m_prev_start = 0; m_prev_hit = 0; m_prev_miss = 0;
            m_pend_hit = 0; m_pend_miss = 0;
        end else begin
            if (m_state != M_PLAY) begin
                if (s && !m_prev_start) begin
                    m_state = M_PLAY; m_score = 0; m_streak = 0; m_timer = 0;
                end
            end else begin
                if (m_pend_miss) begin
                    m_score  = (m_score > 0) ? m_score - 1 : 0;
                    m_streak = 0;
                end else if (m_pend_hit) begin
                    m_score  = m_score + ((m_streak >= CL) ? 2 : 1);
                    if (m_score > 31) m_score = 31;
                    m_streak = (m_streak < 7) ? m_streak + 1 : 7;
                end
                if (m_score == 31) m_state = M_DONE;
                if (m_timer == GT - 1) m_state = M_DONE;
                else m_timer = m_timer + 1;
            end
            m_pend_hit   = h && !m_prev_hit;
            m_pend_miss  = m && !m_prev_miss;
            m_prev_start = s;
            m_prev_hit   = h;
            m_prev_miss  = m;
        end
        exp_q.push_back(pack_exp(m_score, m_streak, m_state));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int sc, input int st,
                             input logic p, input logic o, input logic w);
        check(name, {score, streak, playing, game_over, win},
              {sc[4:0], st[2:0], p, o, w});
    endtask

    task automatic cycle(input logic r, input logic s, input logic h, input logic m);
        logic [10:0] e;
        rst = r; start = s; hit = h; miss = m;
        @(posedge clk);
        model_step(r, s, h, m);
        @(negedge clk);
        e = exp_q.pop_front();
        check("model", {score, streak, playing, game_over, win}, e);
    endtask

    task automatic pulse_hit();
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic pulse_miss();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
    endtask

    task automatic new_game();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic add(input logic r, input logic s, input logic h, input logic m,
                       input logic [4:0] sc, input logic [2:0] st,
                       input logic p, input logic o, input logic w);
        vec_t v;
        v.rst = r; v.start = s; v.hit = h; v.miss = m;
        v.score = sc; v.streak = st; v.playing = p; v.over = o; v.win = w;
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1; start = 0; hit = 0; miss = 0;

        // Three hits then a miss; then six hits crossing the combo threshold.
        add(1,0,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,1,0,0);
        add(0,0,1,0, 0,0,1,0,0); add(0,0,0,0, 1,1,1,0,0);
        add(0,0,1,0, 1,1,1,0,0); add(0,0,0,0, 2,2,1,0,0);
        add(0,0,1,0, 2,2,1,0,0); add(0,0,0,0, 3,3,1,0,0);
        add(0,0,0,1, 3,3,1,0,0); add(0,0,0,0, 2,0,1,0,0);
        add(1,0,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,1,0,0);
        add(0,0,1,0, 0,0,1,0,0); add(0,0,0,0, 1,1,1,0,0);
        add(0,0,1,0, 1,1,1,0,0); add(0,0,0,0, 2,2,1,0,0);
        add(0,0,1,0, 2,2,1,0,0); add(0,0,0,0, 3,3,1,0,0);
        add(0,0,1,0, 3,3,1,0,0); add(0,0,0,0, 4,4,1,0,0);
        add(0,0,1,0, 4,4,1,0,0); add(0,0,0,0, 6,5,1,0,0);
        add(0,0,1,0, 6,5,1,0,0); add(0,0,0,0, 8,6,1,0,0);
        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].rst, vq[i].start, vq[i].hit, vq[i].miss);
            check_out($sformatf("vec%0d", i), int'(vq[i].score), int'(vq[i].streak),
                      vq[i].playing, vq[i].over, vq[i].win);
        end

        // Held hit is a single edge.
        new_game();
        repeat (10) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_out("held_hit", 1, 1, 1, 0, 0);

        // Miss at zero floors; simultaneous hit+miss at 5 is a miss.
        new_game();
        pulse_miss();
        check_out("miss_floor", 0, 0, 1, 0, 0);
        repeat (4) pulse_hit();
        pulse_miss();
        repeat (2) pulse_hit();
        check_out("score_five", 5, 2, 1, 0, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        check_out("hit_and_miss", 4, 0, 1, 0, 0);

        // Timer expiry, ignored hit in DONE, restart from DONE.
        new_game();
        k = 0;
        while (!game_over && k < 60) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check("expiry_cycles", k, 49);
        check_out("expired", 0, 0, 0, 1, 0);
        pulse_hit();
        check_out("done_hit_ignored", 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        check_out("restart", 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Hit scored on the same edge the timer expires.
        new_game();
        repeat (47) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check_out("hit_at_expiry", 1, 1, 0, 1, 0);

        // Perfect score clamps at 31 and freezes.
        new_game();
        repeat (18) pulse_hit();
        check_out("perfect", 31, 7, 0, 1, 1);
        pulse_hit();
        pulse_miss();
        check_out("perfect_frozen", 31, 7, 0, 1, 1);

        // Mid-game reset, then start held through reset release.
        new_game();
        repeat (8) pulse_hit();
        check_out("score_twelve", 12, 7 < 8 ? 7 : 8, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check_out("mid_reset", 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check_out("start_through_reset", 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Randomized games.
        for (int g = 0; g < 40; g++) begin
            new_game();
            for (int c = 0; c < int'($urandom_range(20, 70)); c++) begin
                cycle($urandom_range(0, 200) == 0, $urandom_range(0, 30) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameters: name, default, meaning: GAME_TICKS, 100_000_000, game length in clk cycles (>=2).
REQ-002 Parameter: COMBO_LEN, 4, consecutive hits needed before the double-point bonus.
REQ-003 Parameter: TIMER_W, 27, timer width; SHALL hold GAME_TICKS-1.
REQ-004 Ports: name, direction, width, meaning.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  level; a rising edge begins or restarts a game.
REQ-008 hit  in  1  level from note-judge logic; a rising edge is one hit.
REQ-009 miss  in  1  level from note-judge logic; a rising edge is one miss.
REQ-010 score  out  5  current score, 0..31, drives the seven-segment score decoder.
REQ-011 streak  out  3  consecutive-hit count, saturating at 7.
REQ-012 playing  out  1  high in PLAY.
REQ-013 game_over  out  1  high in DONE.
REQ-014 win  out  1  high in DONE when final score == 31.

Function
REQ-015 Edge detect: one prev register per start/hit/miss, updated every cycle in all states; edge = in & ~prev.
REQ-016 FSM states: IDLE, PLAY, DONE; encoding free; no other reachable state.
REQ-017 IDLE: start edge -> PLAY; score, streak and timer cleared to 0 on the same clk edge.
REQ-018 PLAY: timer increments by 1 per cycle; timer == GAME_TICKS-1 -> DONE at that clk edge.
REQ-019 PLAY: score update that reaches 31 -> DONE at the same clk edge; win = 1.
REQ-020 PLAY: start edge ignored.
REQ-021 DONE: score and streak held; start edge -> PLAY with score, streak and timer cleared.
REQ-022 Hit/miss edges are acted on only while the state register is PLAY; in IDLE and DONE they are discarded.
REQ-023 Hit edge, no miss edge: add 2 if streak (pre-hit) >= COMBO_LEN, else add 1; streak +1, saturating at 7.
REQ-024 Score arithmetic: 6-bit sum, clamped to 31; no wrap-around.
REQ-025 Miss edge: score -1, floored at 0; streak cleared to 0.
REQ-026 Hit and miss edges in the same cycle: treated as a miss only.
REQ-027 Latency: input edge sampled at clk edge N; score/streak visible after clk edge N+1; the register update is one cycle after the input rise.
REQ-028 Timer expiry and a hit in the same cycle: the hit is scored, then the FSM enters DONE.
REQ-029 All outputs are registered or decoded from the state register only; no combinational path from an input to an output.

Reset
REQ-030 rst high at a clk edge: state = IDLE; score = 0; streak = 0; timer = 0; all prev registers = 0; playing = game_over = win = 0.
REQ-031 rst has priority over every other event, including an in-progress game (mid-game reset discards the score).
REQ-032 A start level held high through reset release counts as a start edge on the first cycle after reset.

Verification (bench GAME_TICKS = 50, COMBO_LEN = 4)
REQ-033 Reset, start pulse, 3 hit pulses, 1 miss -> score 3,3,... ending score = 2; streak = 0; playing = 1.
REQ-034 Start, then 6 hit pulses -> score sequence 1,2,3,4,6,8; streak = 6.
REQ-035 Start, then hit held high for 10 cycles -> score = 1 (single edge).
REQ-036 Start, miss before any hit -> score stays 0; hit and miss rising together at score 5 -> score 4, streak 0.
REQ-037 Start, no input for 50 cycles -> game_over = 1, win = 0; later hit ignored; start pulse -> score 0, playing = 1.
REQ-038 Drive score to 31 with hits -> DONE, win = 1, no further changes; rst mid-game at score 12 -> score 0, state IDLE next cycle.
